// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes and immediate formats.
// Also holds the immediate generator and funct3-to-ALU mapping used by the decode stage.
package rv32i_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5
    } imm_type_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_type_e imm_type);
        logic [31:0] imm;
        unique case (imm_type)
            ImmI:    imm = {{20{ins[31]}}, ins[31:20]};
            ImmS:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ImmB:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ImmU:    imm = {ins[31:12], 12'b0};
            ImmJ:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt selects SUB (funct3=000) or SRA (funct3=101); ignored for other funct3 values.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two asynchronous read ports, one synchronous write port.
// x0 reads as zero and ignores writes; no write-to-read bypass here.
module reg_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        raddr1_i,
    input  logic [4:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: combinational decode and operand read feeding a single
// output register bank with stall (hold), flush (bubble) and synchronous reset.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ins,
    input  logic [31:0]       pc_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [31:0]       imm,
    output logic [31:0]       pc_out,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [3:0]        alu_op,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              branch,
    output logic              jump,
    output logic              jalr,
    output logic              valid_out,
    output logic              illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [31:0]       imm;
        logic [31:0]       pc;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        alu_op_e           alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic              valid;
        logic              illegal;
    } id_out_t;

    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic [4:0]        rs1_idx, rs2_idx;
    id_out_t           dec;
    id_out_t           out_q;
    imm_type_e         imm_type;

    assign rs1_idx = ins[19:15];
    assign rs2_idx = ins[24:20];

    reg_file #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .raddr1_i(rs1_idx),
        .raddr2_i(rs2_idx),
        .rdata1_o(rf_rdata1),
        .rdata2_o(rf_rdata2),
        .we_i    (wb_en),
        .waddr_i (wb_rd),
        .wdata_i (wb_data)
    );

    // Writeback in the same cycle as the read must be visible to the decoded instruction.
    assign rs1_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) ? wb_data : rf_rdata1;
    assign rs2_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) ? wb_data : rf_rdata2;

    always_comb begin
        dec      = '0;
        imm_type = ImmNone;
        // An all-zero word is a fetch bubble, not an illegal instruction.
        if (ins != 32'h0) begin
            dec.valid    = 1'b1;
            dec.pc       = pc_in;
            dec.rs1_data = rs1_val;
            dec.rs2_data = rs2_val;
            dec.rd       = ins[11:7];
            dec.funct3   = ins[14:12];
            unique case (ins[6:0])
                OpcLui: begin
                    imm_type = ImmU; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                    dec.alu_op = AluPassB;
                end
                OpcAuipc: begin
                    imm_type = ImmU; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                end
                OpcJal: begin
                    imm_type = ImmJ; dec.reg_write = 1'b1; dec.jump = 1'b1;
                end
                OpcJalr: begin
                    imm_type = ImmI; dec.reg_write = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
                    dec.alu_src = 1'b1;
                end
                OpcBranch: begin
                    imm_type = ImmB; dec.branch = 1'b1; dec.alu_op = AluSub;
                end
                OpcLoad: begin
                    imm_type = ImmI; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
                    dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1;
                end
                OpcStore: begin
                    imm_type = ImmS; dec.mem_write = 1'b1; dec.alu_src = 1'b1;
                end
                OpcOpImm: begin
                    imm_type = ImmI; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                    dec.alu_op = alu_from_funct3(ins[14:12], ins[30] && (ins[14:12] == 3'b101));
                end
                OpcOp: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = alu_from_funct3(ins[14:12], ins[30]);
                end
                OpcFence, OpcSystem: begin
                    dec.rd = '0; dec.funct3 = '0;
                end
                default: begin
                    dec.illegal = 1'b1; dec.rd = '0; dec.funct3 = '0;
                end
            endcase
            dec.imm = gen_imm(ins, imm_type);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_q <= '0;
        end else if (!stall) begin
            out_q <= dec;
        end
    end

    assign rs1_data   = out_q.rs1_data;
    assign rs2_data   = out_q.rs2_data;
    assign imm        = out_q.imm;
    assign pc_out     = out_q.pc;
    assign rd         = out_q.rd;
    assign funct3     = out_q.funct3;
    assign alu_op     = out_q.alu_op;
    assign reg_write  = out_q.reg_write;
    assign mem_read   = out_q.mem_read;
    assign mem_write  = out_q.mem_write;
    assign mem_to_reg = out_q.mem_to_reg;
    assign alu_src    = out_q.alu_src;
    assign branch     = out_q.branch;
    assign jump       = out_q.jump;
    assign jalr       = out_q.jalr;
    assign valid_out  = out_q.valid;
    assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against an architectural reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, wb_en;
    logic [31:0] ins, pc_in, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] rs1_data, rs2_data, imm, pc_out;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic        branch, jump, jalr, valid_out, illegal;

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .ins(ins), .pc_in(pc_in), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc_out(pc_out), .rd(rd),
        .funct3(funct3), .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch),
        .jump(jump), .jalr(jalr), .valid_out(valid_out), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
        logic        branch, jump, jalr, valid, illegal;
    } outs_t;

    outs_t       dut_o;
    outs_t       exp_q = '0;
    logic [31:0] mdl_rf [32];
    int          n_checks = 0;
    int          n_pass = 0;

    assign dut_o = {rs1_data, rs2_data, imm, pc_out, rd, funct3, alu_op, reg_write, mem_read,
                    mem_write, mem_to_reg, alu_src, branch, jump, jalr, valid_out, illegal};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ALU codes by funct3: ADD SLL SLT SLTU XOR SRL OR AND; the alternate form is code+1.
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [3:0] base [8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        return base[f3] + {3'b0, alt && (f3 == 3'd0 || f3 == 3'd5)};
    endfunction

    function automatic outs_t model_decode(input logic [31:0] w, input logic [31:0] pc,
                                           input logic [31:0] v1, input logic [31:0] v2);
        outs_t o;
        int    s;
        o = '0;
        if (w == 32'h0) return o;
        s       = w[31] ? -1 : 0;
        o.valid = 1'b1;
        o.pc    = pc;
        o.rs1   = v1;
        o.rs2   = v2;
        o.rd    = w[11:7];
        o.f3    = w[14:12];
        case (w[6:0])
            7'h37: begin o.reg_write = 1; o.alu_src = 1; o.alu = 4'd10; o.imm = w & 32'hFFFFF000; end
            7'h17: begin o.reg_write = 1; o.alu_src = 1; o.imm = w & 32'hFFFFF000; end
            7'h6F: begin
                o.reg_write = 1; o.jump = 1;
                o.imm = s * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                        + int'(w[30:21]) * 2;
            end
            7'h67: begin
                o.reg_write = 1; o.jump = 1; o.jalr = 1; o.alu_src = 1;
                o.imm = s * 2048 + int'(w[30:20]);
            end
            7'h63: begin
                o.branch = 1; o.alu = 4'd1;
                o.imm = s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'h03: begin
                o.reg_write = 1; o.mem_read = 1; o.mem_to_reg = 1; o.alu_src = 1;
                o.imm = s * 2048 + int'(w[30:20]);
            end
            7'h23: begin
                o.mem_write = 1; o.alu_src = 1;
                o.imm = s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]);
            end
            7'h13: begin
                o.reg_write = 1; o.alu_src = 1; o.imm = s * 2048 + int'(w[30:20]);
                o.alu = alu_code(w[14:12], w[30] && w[14:12] == 3'd5);
            end
            7'h33: begin o.reg_write = 1; o.alu = alu_code(w[14:12], w[30]); end
            7'h0F, 7'h73: begin o.rd = 0; o.f3 = 0; end
            default: begin o.illegal = 1; o.rd = 0; o.f3 = 0; end
        endcase
        return o;
    endfunction

    // Advance one clock: the model sees register values as they stand after this cycle's
    // writeback, then the DUT outputs are compared just after the edge.
    task automatic step();
        logic [31:0] rf_after [32];
        rf_after = mdl_rf;
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_after[i] = '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            rf_after[wb_rd] = wb_data;
        end
        if (reset || flush) exp_q = '0;
        else if (!stall) exp_q = model_decode(ins, pc_in, rf_after[ins[19:15]],
                                              rf_after[ins[24:20]]);
        mdl_rf = rf_after;
        @(posedge clk);
        #1;
        chk("model", 160'(dut_o), 160'(exp_q));
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  opcs [11];
        logic [31:0] r;
        int          k;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        r = $urandom();
        k = $urandom_range(0, 13);
        if (k < 11) return {r[31:7], opcs[k]};
        if (k == 11) return 32'h0;
        if (k == 12) return 32'hFFFF_FFFF;
        return r;
    endfunction

    logic [9:0] ctrl_bits;
    assign ctrl_bits = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, jalr,
                        valid_out, illegal};

    initial begin
        for (int i = 0; i < 32; i++) mdl_rf[i] = '0;
        reset = 1; stall = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        ins = 32'h0; pc_in = 32'h0;
        step();
        step();
        chk("reset outputs", 160'(dut_o), 160'd0);

        reset = 0; ins = 32'h0050_0093; pc_in = 32'h100;
        step();
        chk("addi alu_op", 160'(alu_op), 160'd0);
        chk("addi alu_src", 160'(alu_src), 160'd1);
        chk("addi reg_write", 160'(reg_write), 160'd1);
        chk("addi rd", 160'(rd), 160'd1);
        chk("addi imm", 160'(imm), 160'd5);
        chk("addi rs1_data", 160'(rs1_data), 160'd0);
        chk("addi pc_out", 160'(pc_out), 160'h100);

        wb_en = 1; wb_rd = 2; wb_data = 32'hDEAD_BEEF; ins = 32'h0021_0133;
        step();
        chk("bypass rs2_data", 160'(rs2_data), 160'hDEAD_BEEF);
        chk("bypass alu_op", 160'(alu_op), 160'd0);

        wb_en = 0; ins = 32'hFE00_0EE3;
        step();
        chk("beq branch", 160'(branch), 160'd1);
        chk("beq imm", 160'(imm), 160'hFFFF_FFFC);
        chk("beq funct3", 160'(funct3), 160'd0);

        stall = 1; flush = 1; ins = 32'h0050_0093;
        step();
        chk("stall+flush ctrl", 160'(ctrl_bits), 160'd0);
        stall = 0; flush = 0;
        step();
        stall = 1; ins = 32'hFFFF_FFFF; wb_en = 1; wb_rd = 3; wb_data = 32'h55;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall hold imm", 160'(imm), 160'd5);
            chk("stall hold ctrl", 160'(ctrl_bits), 160'b1000100010);
            wb_en = 0;
        end
        stall = 0; ins = 32'h0001_8233;
        step();
        chk("wb during stall", 160'(rs1_data), 160'h55);

        ins = 32'hFFFF_FFFF;
        step();
        chk("illegal flag", 160'(illegal), 160'd1);
        chk("illegal reg_write", 160'(reg_write), 160'd0);
        ins = 32'h0;
        step();
        chk("zero word valid/illegal", 160'({valid_out, illegal}), 160'd0);

        wb_en = 1; wb_rd = 5; wb_data = 32'd7;
        step();
        wb_en = 0; ins = 32'h0002_80B3;
        step();
        chk("x5 before reset", 160'(rs1_data), 160'd7);
        reset = 1; wb_en = 1; wb_rd = 5; wb_data = 32'd9; ins = 32'h0050_0093;
        step();
        chk("mid-stream reset", 160'(dut_o), 160'd0);
        reset = 0; wb_en = 0; ins = 32'h0;
        step();
        chk("valid after reset", 160'(valid_out), 160'd0);
        ins = 32'h0002_80B3;
        step();
        chk("x5 after reset", 160'(rs1_data), 160'd0);

        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 99) < 8);
            stall   = ($urandom_range(0, 99) < 20);
            wb_en   = $urandom_range(0, 1) == 1;
            wb_rd   = 5'($urandom_range(0, 31));
            wb_data = $urandom();
            pc_in   = $urandom();
            ins     = rand_ins();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter NUM_REGS, default 32, register-file depth (x0..x31).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ins  input  32  instruction word, and pc_in  input  32  its word address; both from the fetch stage.
REQ-006 SHALL have ports stall  input  1  hold outputs, and flush  input  1  insert bubble.
REQ-007 SHALL have ports wb_en  input  1, wb_rd  input  5, wb_data  input  32  writeback port.
REQ-008 SHALL have ports rs1_data, rs2_data, imm, pc_out  output  32 each; registered operands, sign-extended immediate, passed PC.
REQ-009 SHALL have ports rd  output  5, funct3  output  3, alu_op  output  4  (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,PASSB).
REQ-010 SHALL have 1-bit outputs reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, jalr, valid_out, illegal.

Function
REQ-011 SHALL register all outputs: instruction on ins at edge N appears on outputs after edge N+1 (1-cycle latency).
REQ-012 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; FENCE/SYSTEM decode as NOP with valid_out=1, all control 0.
REQ-013 SHALL generate imm per type: I {20{ins[31]},ins[31:20]}; S {20{ins[31]},ins[31:25],ins[11:7]}; B {19{ins[31]},ins[31],ins[7],ins[30:25],ins[11:8],0}; U {ins[31:12],12'b0}; J {11{ins[31]},ins[31],ins[19:12],ins[20],ins[30:21],0}; R-type imm=0.
REQ-014 SHALL select SUB/SRA only when ins[30]=1 for OP; for OP-IMM ins[30] selects SRA only with funct3=101.
REQ-015 SHALL read rs1=ins[19:15], rs2=ins[24:20] combinationally from the register file and register the values.
REQ-016 SHALL bypass wb_data to rs1_data/rs2_data when wb_en=1, wb_rd equal to the source index, and wb_rd!=0 (same-cycle write/read).
REQ-017 SHALL write register file on rising edge when wb_en=1 and wb_rd!=0; writes to x0 ignored; x0 reads 0 always.
REQ-018 SHALL hold every output unchanged while stall=1; register-file writeback continues during stall.
REQ-019 SHALL, when flush=1, load a bubble: valid_out=0, all control bits 0, illegal=0; flush has priority over stall.
REQ-020 SHALL treat ins=32'h0000_0000 as a bubble (valid_out=0, illegal=0), not as illegal.
REQ-021 SHALL set illegal=1, valid_out=1, all other control 0 for unknown opcode or ins[1:0]!=2'b11 (non-zero word).
REQ-022 SHALL pass pc_in to pc_out unmodified (word address); no branch-target arithmetic in this block.

Reset
REQ-023 SHALL, on reset=1 at a rising edge, clear all outputs to 0 and all registers x1..x31 to 0.
REQ-024 SHALL give reset priority over flush, stall and wb_en; writeback during reset cycle is discarded.
REQ-025 SHALL emit valid_out=0 on the first edge after reset deasserts unless a valid instruction was present on ins in that cycle.

Structure
REQ-026 SHALL place opcode constants, alu_op encodings and immediate-type codes in shared package rv32i_pkg.
REQ-027 SHALL instantiate one sub-module reg_file (2 async read, 1 sync write, x0 hardwired, no bypass inside).
REQ-028 SHALL keep decode combinational ahead of a single output register bank.

Verification
REQ-029 SHALL check: ins=32'h00500093 (addi x1,x0,5) -> next cycle alu_op=ADD, alu_src=1, reg_write=1, rd=1, imm=5, rs1_data=0.
REQ-030 SHALL check: wb_en=1, wb_rd=2, wb_data=32'hDEAD_BEEF with ins=32'h00210133 same cycle -> rs2_data=32'hDEAD_BEEF (bypass).
REQ-031 SHALL check: ins=32'hFE000EE3 (beq x0,x0,-4) -> branch=1, imm=32'hFFFF_FFFC, funct3=000.
REQ-032 SHALL check: stall=1 and flush=1 together for one cycle -> valid_out=0, all control 0; stall alone 3 cycles -> outputs constant.
REQ-033 SHALL check: ins=32'hFFFFFFFF -> illegal=1, reg_write=0; ins=0 -> valid_out=0, illegal=0.
REQ-034 SHALL check: reset=1 mid-stream after writing x5=7 -> all outputs 0; later read of x5 returns 0.
